// File: rtl/btype_pkg.sv
// Shared definitions for the B-type branch datapath and its control sequencer.
// Holds the opcode and funct3 constants, the controller state encoding and the legality check.
package btype_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    TRAP   = 2'd3
  } ctrl_state_t;

  // funct3 values 010 and 011 are unused in the branch opcode space.
  function automatic logic isLegalBranch(input logic [6:0] opcode, input logic [2:0] funct3);
    return (opcode == OP_BRANCH) && (funct3 != 3'b010) && (funct3 != 3'b011);
  endfunction

endpackage

// File: rtl/btype_ctrl_if.sv
// Instruction-memory fetch handshake between the branch sequencer and instruction memory.
// The master side issues imem_req; the slave side answers with imem_ready and imem_rdata.
interface btype_ctrl_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, output imem_ready, output imem_rdata);
endinterface

// File: rtl/btype_cond.sv
// Combinational branch-condition evaluator.
// Turns funct3 and the datapath comparator flags into a taken decision.
module btype_cond
  import btype_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       cmp_eq_i,
  input  logic       cmp_lt_i,
  input  logic       cmp_ltu_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_o = cmp_eq_i;
      F3_BNE:  taken_o = !cmp_eq_i;
      F3_BLT:  taken_o = cmp_lt_i;
      F3_BGE:  taken_o = !cmp_lt_i;
      F3_BLTU: taken_o = cmp_ltu_i;
      F3_BGEU: taken_o = !cmp_ltu_i;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/btype_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/TRAP sequencer for conditional branches.
// Optional branch statistics counters are compiled in when BTYPE_CTRL_STATS_EN is defined.
module btype_ctrl
  import btype_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  btype_ctrl_if.master      imem,
  output logic              ir_we,
  output logic              rf_re,
  input  logic              cmp_eq,
  input  logic              cmp_lt,
  input  logic              cmp_ltu,
  output logic              pc_we,
  output logic              pc_sel,
  output logic              illegal,
  output logic [1:0]        state_o,
  output logic [STAT_W-1:0] taken_cnt,
  output logic [STAT_W-1:0] branch_cnt
);

  ctrl_state_t state_q, state_d;
  logic [6:0]  opcode_q;
  logic [2:0]  funct3_q;
  logic        taken;
  logic        imemReq, irWe, rfRe, pcWe, pcSel, illegalPulse;

  btype_cond uCond (
    .funct3_i  (funct3_q),
    .cmp_eq_i  (cmp_eq),
    .cmp_lt_i  (cmp_lt),
    .cmp_ltu_i (cmp_ltu),
    .taken_o   (taken)
  );

  // Reset takes priority so a fetch completing in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= FETCH;
      opcode_q <= '0;
      funct3_q <= '0;
    end else begin
      state_q <= state_d;
      if (irWe) begin
        opcode_q <= imem.imem_rdata[6:0];
        funct3_q <= imem.imem_rdata[14:12];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    imemReq      = 1'b0;
    irWe         = 1'b0;
    rfRe         = 1'b0;
    pcWe         = 1'b0;
    pcSel        = 1'b0;
    illegalPulse = 1'b0;
    case (state_q)
      FETCH: begin
        imemReq = 1'b1;
        if (imem.imem_ready) begin
          irWe    = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        rfRe    = 1'b1;
        state_d = isLegalBranch(opcode_q, funct3_q) ? EXEC : TRAP;
      end
      EXEC: begin
        pcWe    = 1'b1;
        pcSel   = taken;
        state_d = FETCH;
      end
      TRAP: begin
        illegalPulse = 1'b1;
        pcWe         = 1'b1;
        state_d      = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Every output is held low for as long as reset is asserted, even before the first edge.
  assign imem.imem_req = reset & imemReq;
  assign ir_we         = reset & irWe;
  assign rf_re         = reset & rfRe;
  assign pc_we         = reset & pcWe;
  assign pc_sel        = reset & pcSel;
  assign illegal       = reset & illegalPulse;
  assign state_o       = reset ? state_q : 2'b00;

`ifdef BTYPE_CTRL_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  logic [STAT_W-1:0] takenCnt_q, branchCnt_q;

  // Saturating counters; TRAP cycles never reach EXEC so they are not counted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      takenCnt_q  <= '0;
      branchCnt_q <= '0;
    end else if (state_q == EXEC) begin
      if (branchCnt_q != STAT_MAX) branchCnt_q <= branchCnt_q + 1'b1;
      if (taken && (takenCnt_q != STAT_MAX)) takenCnt_q <= takenCnt_q + 1'b1;
    end
  end

  assign taken_cnt  = reset ? takenCnt_q : '0;
  assign branch_cnt = reset ? branchCnt_q : '0;
`else
  assign taken_cnt  = '0;
  assign branch_cnt = '0;
`endif

endmodule

// File: tb/tb_btype_ctrl.sv
// Self-checking bench for btype_ctrl: directed scenarios plus randomized branches
// compared against a transaction-level timeline and operand-based branch model.
module tb_btype_ctrl;
  import btype_pkg::*;

  localparam int XLEN   = 32;
  localparam int STAT_W = 4;
  localparam int SAT    = (1 << STAT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              ir_we, rf_re, pc_we, pc_sel, illegal;
  logic              cmp_eq = 1'b0, cmp_lt = 1'b0, cmp_ltu = 1'b0;
  logic [1:0]        state_o;
  logic [STAT_W-1:0] taken_cnt, branch_cnt;

  int total = 0;
  int bad   = 0;
  int modelBranch = 0;
  int modelTaken  = 0;

  btype_ctrl_if #(.XLEN(XLEN)) imemIf ();

  btype_ctrl #(.XLEN(XLEN), .STAT_W(STAT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem       (imemIf),
    .ir_we      (ir_we),
    .rf_re      (rf_re),
    .cmp_eq     (cmp_eq),
    .cmp_lt     (cmp_lt),
    .cmp_ltu    (cmp_ltu),
    .pc_we      (pc_we),
    .pc_sel     (pc_sel),
    .illegal    (illegal),
    .state_o    (state_o),
    .taken_cnt  (taken_cnt),
    .branch_cnt (branch_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int expCnt(input int v);
`ifdef BTYPE_CTRL_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  // Architectural branch semantics on the operand values themselves.
  function automatic bit refTaken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkStrobes(input string tag, input logic req, input logic ir, input logic rf,
                              input logic pcwe, input logic pcsel, input logic ill, input int st);
    @(negedge clk);
    checkOutput({tag, ".imem_req"}, 32'(imemIf.imem_req), 32'(req));
    checkOutput({tag, ".ir_we"},    32'(ir_we),   32'(ir));
    checkOutput({tag, ".rf_re"},    32'(rf_re),   32'(rf));
    checkOutput({tag, ".pc_we"},    32'(pc_we),   32'(pcwe));
    checkOutput({tag, ".pc_sel"},   32'(pc_sel),  32'(pcsel));
    checkOutput({tag, ".illegal"},  32'(illegal), 32'(ill));
    checkOutput({tag, ".state"},    32'(state_o), st);
    checkOutput({tag, ".branch_cnt"}, 32'(branch_cnt), expCnt(modelBranch));
    checkOutput({tag, ".taken_cnt"},  32'(taken_cnt),  expCnt(modelTaken));
  endtask

  task automatic randomJunk();
    imemIf.imem_rdata = $urandom;
    cmp_eq  = 1'($urandom);
    cmp_lt  = 1'($urandom);
    cmp_ltu = 1'($urandom);
  endtask

  // One whole instruction starting in its first FETCH cycle: waitCycles stalls, then DECODE, then EXEC/TRAP.
  task automatic applyStimulus(input string tag, input logic [31:0] instr, input int waitCycles,
                               input logic [31:0] a, input logic [31:0] b);
    logic [6:0] op;
    logic [2:0] f3;
    bit legal, tk;
    op = instr[6:0];
    f3 = instr[14:12];
    legal = (op == 7'b1100011) && (f3 != 3'b010) && (f3 != 3'b011);
    tk = legal && refTaken(f3, a, b);
    for (int c = 0; c <= waitCycles; c++) begin
      randomJunk();
      imemIf.imem_ready = (c == waitCycles);
      if (c == waitCycles) imemIf.imem_rdata = instr;
      checkStrobes({tag, ".fetch"}, 1'b1, (c == waitCycles), 1'b0, 1'b0, 1'b0, 1'b0, 0);
      nextCycle();
    end
    randomJunk();
    imemIf.imem_ready = 1'($urandom);
    checkStrobes({tag, ".decode"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    nextCycle();
    imemIf.imem_rdata = $urandom;
    imemIf.imem_ready = 1'($urandom);
    cmp_eq  = (a == b);
    cmp_lt  = ($signed(a) < $signed(b));
    cmp_ltu = (a < b);
    checkStrobes({tag, ".exec"}, 1'b0, 1'b0, 1'b0, 1'b1, tk, !legal, legal ? 2 : 3);
    nextCycle();
    if (legal) begin
      if (modelBranch < SAT) modelBranch++;
      if (tk && modelTaken < SAT) modelTaken++;
    end
  endtask

  task automatic applyReset(input int cycles);
    reset = 1'b0;
    modelBranch = 0;
    modelTaken  = 0;
    for (int c = 0; c < cycles; c++) begin
      randomJunk();
      imemIf.imem_ready = 1'($urandom);
      checkStrobes("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      nextCycle();
    end
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] instr, a, b;
    imemIf.imem_ready = 1'b0;
    imemIf.imem_rdata = '0;
    applyReset(3);

    applyStimulus("beqTaken", 32'h00208463, 0, 32'd5, 32'd5);
    applyStimulus("bgeuNotTaken", 32'h0020f463, 0, 32'd1, 32'd2);
    applyStimulus("illegalF3", 32'h00202463, 0, 32'd9, 32'd9);
    applyStimulus("illegalOp", 32'h002080b3, 0, 32'd9, 32'd9);
    applyStimulus("memWait", 32'h00208463, 4, 32'd3, 32'd7);

    // Reset during DECODE, then again during FETCH with a ready instruction.
    randomJunk();
    imemIf.imem_ready = 1'b1;
    imemIf.imem_rdata = 32'h00208463;
    checkStrobes("midop.fetch", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    nextCycle();
    reset = 1'b0;
    modelBranch = 0;
    modelTaken  = 0;
    checkStrobes("midop.decodeRst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    nextCycle();
    imemIf.imem_ready = 1'b1;
    imemIf.imem_rdata = 32'h00208463;
    cmp_eq = 1'b1;
    checkStrobes("midop.fetchRst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    nextCycle();
    reset = 1'b1;
    applyStimulus("afterRst", 32'h00209463, 1, 32'd4, 32'd8);

    for (int i = 0; i < 17; i++) applyStimulus("sat", 32'h00208463, 0, 32'd7, 32'd7);
    @(negedge clk);
    checkOutput("satTaken", 32'(taken_cnt), expCnt(SAT));
    checkOutput("satBranch", 32'(branch_cnt), expCnt(SAT));
    nextCycle();

    for (int i = 0; i < 300; i++) begin
      instr = $urandom;
      if (($urandom % 4) != 0) instr[6:0] = 7'b1100011;
      a = $urandom;
      b = (($urandom % 3) == 0) ? a : 32'($urandom);
      if (($urandom % 8) == 0) begin
        applyReset(int'($urandom_range(1, 3)));
      end
      applyStimulus("rand", instr, int'($urandom_range(0, 3)), a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
